accel_mode_seq: RTL

- Parametrised run sequencer and lane forwarding stage between the host command interface, the systolic array and the accumulator/pool block.
- Replaces plain level decoding of the start field with the following:
  - a command handshake;
  - one-cycle engine start pulses;
  - counting of expected result beats;
  - a timeout;
  - abort handling;
  - done/error reporting.
- Forwards LANES partial-sum lanes through one register stage, with valids gated to the active run.

---
 rtl/accel_pkg.sv | 31 +++
 rtl/psum_lane_pipe.sv | 44 ++++
 rtl/accel_mode_seq.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/accel_pkg.sv
// Shared types and defaults for the accelerator run sequencer slice.
//   mode_e      : command mode field encoding
//   seq_state_e : sequencer FSM states
//   DEF_*       : default lane/counter geometry
//   is_run_mode : true for modes that launch an engine run
package accel_pkg;

    localparam int unsigned DEF_LANES  = 16;
    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_CNT_W  = 16;
    localparam int unsigned DEF_TMO_W  = 12;

    typedef enum logic [1:0] {
        NOP     = 2'd0,
        CONV    = 2'd1,
        FC      = 2'd2,
        ILLEGAL = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        DRAIN  = 2'd3
    } seq_state_e;

    function automatic logic is_run_mode(input mode_e m);
        return (m == CONV) || (m == FC);
    endfunction

endpackage

// File: rtl/psum_lane_pipe.sv
// One register stage for the partial-sum lanes.
//   clk, rst_n : clock, synchronous active-low reset
//   gate_i     : when low, valids entering this cycle are dropped
//   data_i     : LANES*DATA_W lane data, registered unconditionally
//   valid_i    : per-lane valid
//   data_o     : registered lane data
//   valid_o    : registered, gated lane valid
module psum_lane_pipe
    import accel_pkg::*;
#(
    parameter int unsigned LANES  = DEF_LANES,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    gate_i,
    input  logic [LANES*DATA_W-1:0] data_i,
    input  logic [LANES-1:0]        valid_i,
    output logic [LANES*DATA_W-1:0] data_o,
    output logic [LANES-1:0]        valid_o
);

    logic [LANES*DATA_W-1:0] data_q, data_d;
    logic [LANES-1:0]        valid_q, valid_d;

    always_comb begin
        data_d  = data_i;
        valid_d = valid_i & {LANES{gate_i}};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/accel_mode_seq.sv
// Run sequencer and lane forwarding stage between the host command port,
// the systolic array and the accumulator/pool block.
//   cmd_*            : command handshake (mode, conv index, expected beats)
//   abort_i          : cancels the current run
//   start_sa_o/fc_o  : one-cycle engine start pulses
//   nth_conv_o       : latched conv index
//   lane_*_i/_o      : psum lanes, one register stage, valids gated to RUN
//   beat_cnt_o       : beats seen in current/last run (saturating)
//   busy_o, done_o, err_o : status, completion pulse, error pulse
module accel_mode_seq
    import accel_pkg::*;
#(
    parameter int unsigned LANES  = DEF_LANES,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned CNT_W  = DEF_CNT_W,
    parameter int unsigned TMO_W  = DEF_TMO_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [1:0]              cmd_mode_i,
    input  logic [1:0]              cmd_conv_idx_i,
    input  logic [CNT_W-1:0]        cmd_beats_i,
    input  logic                    abort_i,
    output logic                    start_sa_o,
    output logic                    start_fc_o,
    output logic [1:0]              nth_conv_o,
    input  logic [LANES*DATA_W-1:0] lane_data_i,
    input  logic [LANES-1:0]        lane_valid_i,
    output logic [LANES*DATA_W-1:0] lane_data_o,
    output logic [LANES-1:0]        lane_valid_o,
    output logic [CNT_W-1:0]        beat_cnt_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o
);

    // Idle-counter value one short of all-ones: the next idle cycle times out.
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    seq_state_e       state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [1:0]       conv_idx_q, conv_idx_d;
    logic [CNT_W-1:0] beats_q, beats_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             start_sa_q, start_sa_d;
    logic             start_fc_q, start_fc_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             accept;
    logic             beat;
    mode_e            cmd_mode;
    logic             lane_gate;

    always_comb begin
        cmd_mode = mode_e'(cmd_mode_i);
        accept   = cmd_valid_i & ready_q;
        beat     = |lane_valid_i;

        state_d    = state_q;
        mode_d     = mode_q;
        conv_idx_d = conv_idx_q;
        beats_d    = beats_q;
        beat_cnt_d = beat_cnt_q;
        tmo_d      = tmo_q;
        err_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (cmd_mode == ILLEGAL) begin
                        err_d = 1'b1;
                    end else if (is_run_mode(cmd_mode)) begin
                        mode_d     = cmd_mode;
                        conv_idx_d = cmd_conv_idx_i;
                        beats_d    = cmd_beats_i;
                        beat_cnt_d = '0;
                        tmo_d      = '0;
                        state_d    = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                state_d = (beats_q == '0) ? DRAIN : RUN;
            end
            RUN: begin
                if (beat) begin
                    if (beat_cnt_q != '1) begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                    tmo_d = '0;
                    if (beat_cnt_q == beats_q - CNT_W'(1)) begin
                        state_d = DRAIN;
                    end
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                    if (tmo_q == TMO_LAST) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides whatever the state logic decided this cycle,
        // including a coincident final beat or timeout.
        if (abort_i && (state_q != IDLE)) begin
            state_d    = IDLE;
            beat_cnt_d = beat_cnt_q;
            tmo_d      = tmo_q;
            err_d      = 1'b0;
        end

        // Outputs are registered from the next state so they line up with it.
        ready_d    = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DRAIN);
        start_sa_d = (state_d == LAUNCH) && (mode_d == CONV);
        start_fc_d = (state_d == LAUNCH) && (mode_d == FC);

        lane_gate  = (state_q == RUN) && !abort_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mode_q     <= NOP;
            conv_idx_q <= '0;
            beats_q    <= '0;
            beat_cnt_q <= '0;
            tmo_q      <= '0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            start_sa_q <= 1'b0;
            start_fc_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            conv_idx_q <= conv_idx_d;
            beats_q    <= beats_d;
            beat_cnt_q <= beat_cnt_d;
            tmo_q      <= tmo_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            start_sa_q <= start_sa_d;
            start_fc_q <= start_fc_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    psum_lane_pipe #(
        .LANES  (LANES),
        .DATA_W (DATA_W)
    ) u_lane_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .gate_i  (lane_gate),
        .data_i  (lane_data_i),
        .valid_i (lane_valid_i),
        .data_o  (lane_data_o),
        .valid_o (lane_valid_o)
    );

    assign cmd_ready_o = ready_q;
    assign busy_o      = busy_q;
    assign start_sa_o  = start_sa_q;
    assign start_fc_o  = start_fc_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign nth_conv_o  = conv_idx_q;
    assign beat_cnt_o  = beat_cnt_q;

endmodule
